// File: rtl/d_unit_if.sv
// Decode-stage bundle: F->D inputs, forwarded operands, hazard controls, and the
// fetch-steering and D->E register outputs. Clk/Reset stay plain ports on d_unit.
interface d_unit_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      IRD;
    logic [31:0]      PC4D;
    logic [6:2]       ExcCode_D;
    logic             BD_D;
    logic [31:0]      RS_D_OUT;
    logic [31:0]      RT_D_OUT;
    logic             Stall;
    logic             EXC_F;

    logic [31:0]      NPC;
    logic [2:0]       PCsrc;
    logic             Branch;
    logic             PauseF;
    logic             PauseD;
    logic [31:0]      IRE;
    logic [31:0]      PC4E;
    logic [31:0]      LINKE;
    logic [31:0]      RSE;
    logic [31:0]      RTE;
    logic [31:0]      EXTE;
    logic [6:2]       ExcCode_E;
    logic             BD_E;
    logic [CNT_W-1:0] StallCnt;

    modport master (
        output IRD, PC4D, ExcCode_D, BD_D, RS_D_OUT, RT_D_OUT, Stall, EXC_F,
        input  NPC, PCsrc, Branch, PauseF, PauseD,
        input  IRE, PC4E, LINKE, RSE, RTE, EXTE, ExcCode_E, BD_E, StallCnt
    );

    modport slave (
        input  IRD, PC4D, ExcCode_D, BD_D, RS_D_OUT, RT_D_OUT, Stall, EXC_F,
        output NPC, PCsrc, Branch, PauseF, PauseD,
        output IRE, PC4E, LINKE, RSE, RTE, EXTE, ExcCode_E, BD_E, StallCnt
    );
endinterface

// File: rtl/d_unit.sv
// Decode stage: branch/jump resolution, stall pauses and the D->E pipeline register.
// Optional saturating stall-cycle counter enabled by defining D_STALL_CNT_EN.
module d_unit #(
    parameter logic [4:0] EXC_NONE = 5'b11111,
    parameter int         CNT_W    = 32
) (
    input  logic    Clk,
    input  logic    Reset,
    d_unit_if.slave bus
);
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [5:0] FN_ERET    = 6'b011000;

    logic [5:0]         opcode;
    logic [4:0]         rs_f;
    logic [4:0]         rt_f;
    logic [5:0]         funct;
    logic signed [31:0] rs_s;
    logic [31:0]        imm_sext;
    logic [31:0]        br_target;
    logic [31:0]        j_target;
    logic               is_jr;
    logic               is_jalr;
    logic               is_jal;
    logic               is_eret;
    logic               is_logic_imm;
    logic               pause;

    assign opcode       = bus.IRD[31:26];
    assign rs_f         = bus.IRD[25:21];
    assign rt_f         = bus.IRD[20:16];
    assign funct        = bus.IRD[5:0];
    assign rs_s         = bus.RS_D_OUT;
    assign imm_sext     = {{16{bus.IRD[15]}}, bus.IRD[15:0]};
    assign br_target    = bus.PC4D + {imm_sext[29:0], 2'b00};
    assign j_target     = {bus.PC4D[31:28], bus.IRD[25:0], 2'b00};
    assign is_jr        = (opcode == OP_SPECIAL) && (funct == FN_JR);
    assign is_jalr      = (opcode == OP_SPECIAL) && (funct == FN_JALR);
    assign is_jal       = (opcode == OP_JAL);
    assign is_eret      = (opcode == OP_COP0) && (rs_f == 5'b10000) && (funct == FN_ERET);
    assign is_logic_imm = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);

    // Flush overrides stall so the PC can be redirected to the handler.
    assign pause      = bus.Stall & ~bus.EXC_F;
    assign bus.PauseF = pause;
    assign bus.PauseD = pause;

    // Branch target is driven on NPC even when not taken; PCsrc alone selects.
    always_comb begin
        bus.NPC    = bus.PC4D;
        bus.PCsrc  = 3'd0;
        bus.Branch = 1'b0;
        case (opcode)
            OP_BEQ: begin
                bus.NPC    = br_target;
                bus.Branch = 1'b1;
                bus.PCsrc  = (bus.RS_D_OUT == bus.RT_D_OUT) ? 3'd1 : 3'd0;
            end
            OP_BNE: begin
                bus.NPC    = br_target;
                bus.Branch = 1'b1;
                bus.PCsrc  = (bus.RS_D_OUT != bus.RT_D_OUT) ? 3'd1 : 3'd0;
            end
            OP_BLEZ: begin
                bus.NPC    = br_target;
                bus.Branch = 1'b1;
                bus.PCsrc  = (rs_s <= 0) ? 3'd1 : 3'd0;
            end
            OP_BGTZ: begin
                bus.NPC    = br_target;
                bus.Branch = 1'b1;
                bus.PCsrc  = (rs_s > 0) ? 3'd1 : 3'd0;
            end
            OP_REGIMM: begin
                if (rt_f == 5'd0 || rt_f == 5'd1) begin
                    bus.NPC    = br_target;
                    bus.Branch = 1'b1;
                    // rt=0 is bltz, rt=1 is bgez: taken when sign bit differs from rt[0].
                    bus.PCsrc  = (rs_s[31] != rt_f[0]) ? 3'd1 : 3'd0;
                end
            end
            OP_J, OP_JAL: begin
                bus.NPC    = j_target;
                bus.Branch = 1'b1;
                bus.PCsrc  = 3'd1;
            end
            OP_SPECIAL: begin
                if (is_jr || is_jalr) begin
                    bus.Branch = 1'b1;
                    bus.PCsrc  = 3'd2;
                end
            end
            OP_COP0: begin
                if (is_eret) begin
                    bus.PCsrc = 3'd3;
                end
            end
            default: ;
        endcase
    end

    logic [31:0] ire_q, ire_d;
    logic [31:0] pc4e_q, pc4e_d;
    logic [31:0] linke_q, linke_d;
    logic [31:0] rse_q, rse_d;
    logic [31:0] rte_q, rte_d;
    logic [31:0] exte_q, exte_d;
    logic [4:0]  exc_e_q, exc_e_d;
    logic        bd_e_q, bd_e_d;

    always_comb begin
        ire_d   = bus.IRD;
        pc4e_d  = bus.PC4D;
        linke_d = (is_jal || is_jalr) ? (bus.PC4D + 32'd4) : 32'd0;
        rse_d   = bus.RS_D_OUT;
        rte_d   = bus.RT_D_OUT;
        exte_d  = is_logic_imm ? {16'd0, bus.IRD[15:0]} : imm_sext;
        exc_e_d = bus.ExcCode_D;
        bd_e_d  = bus.BD_D;
        // Flush and stall both inject the same bubble.
        if (bus.EXC_F || bus.Stall) begin
            ire_d   = '0;
            pc4e_d  = '0;
            linke_d = '0;
            rse_d   = '0;
            rte_d   = '0;
            exte_d  = '0;
            exc_e_d = EXC_NONE;
            bd_e_d  = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ire_q   <= '0;
            pc4e_q  <= '0;
            linke_q <= '0;
            rse_q   <= '0;
            rte_q   <= '0;
            exte_q  <= '0;
            exc_e_q <= EXC_NONE;
            bd_e_q  <= 1'b0;
        end else begin
            ire_q   <= ire_d;
            pc4e_q  <= pc4e_d;
            linke_q <= linke_d;
            rse_q   <= rse_d;
            rte_q   <= rte_d;
            exte_q  <= exte_d;
            exc_e_q <= exc_e_d;
            bd_e_q  <= bd_e_d;
        end
    end

    assign bus.IRE       = ire_q;
    assign bus.PC4E      = pc4e_q;
    assign bus.LINKE     = linke_q;
    assign bus.RSE       = rse_q;
    assign bus.RTE       = rte_q;
    assign bus.EXTE      = exte_q;
    assign bus.ExcCode_E = exc_e_q;
    assign bus.BD_E      = bd_e_q;

`ifdef D_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pause && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.StallCnt = cnt_q;
`else
    assign bus.StallCnt = '0;
`endif
endmodule
